// File: rtl/axi_loopback_engine.sv
// AXI read-to-write loopback engine: reads num_beats from src_addr, optionally transforms,
// and writes them to dst_addr through an internal FIFO, one burst at a time per direction.
module axi_loopback_engine #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_BURST       = 16,
  parameter int FIFO_ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [ADDR_WIDTH-1:0]   dst_addr,
  input  logic [15:0]             num_beats,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [3:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int          BYTES = DATA_WIDTH / 8;
  localparam int          SIZE  = $clog2(BYTES);
  localparam int          FA    = FIFO_ADDR_WIDTH;
  localparam int          DEPTH = 1 << FA;
  localparam logic [15:0] MAXB  = 16'(MAX_BURST);

  typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_e;
  typedef enum logic [2:0] {WR_IDLE, WR_AW, WR_W, WR_B, WR_FIN} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;

  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [15:0]           rd_rem_q, rd_rem_d, wr_rem_q, wr_rem_d;
  logic [15:0]           wr_burst_q, wr_burst_d, wr_beat_q, wr_beat_d, wr_idx_q, wr_idx_d;

  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [3:0]            arlen_q, arlen_d, awlen_q, awlen_d;
  logic [2:0]            arsize_q, arsize_d, awsize_q, awsize_d;
  logic [1:0]            arburst_q, arburst_d, awburst_q, awburst_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                  wlast_q, wlast_d, bready_q, bready_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]      wstrb_q, wstrb_d;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] fifo_mem_q, fifo_mem_d;
  logic [FA-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
  logic [FA:0]           cnt_q, cnt_d, free;
  logic                  push, pop;
  logic [15:0]           rd_beats, wr_beats;

  function automatic logic [DATA_WIDTH-1:0] xform(input logic [1:0] m,
                                                  input logic [DATA_WIDTH-1:0] d,
                                                  input logic [15:0] idx);
    case (m)
      2'd1:    return ~d;
      2'd2:    return DATA_WIDTH'(idx);
      default: return d;
    endcase
  endfunction

  assign rd_beats   = (rd_rem_q > MAXB) ? MAXB : rd_rem_q;
  assign wr_beats   = (wr_rem_q > MAXB) ? MAXB : wr_rem_q;
  assign free       = (FA+1)'(DEPTH) - cnt_q;
  assign rd_ptr_nxt = rd_ptr_q + FA'(1);

  always_comb begin
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    mode_d     = mode_q;
    rd_state_d = rd_state_q;
    wr_state_d = wr_state_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    rd_rem_d   = rd_rem_q;
    wr_rem_d   = wr_rem_q;
    wr_burst_d = wr_burst_q;
    wr_beat_d  = wr_beat_q;
    wr_idx_d   = wr_idx_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arsize_d   = arsize_q;
    arburst_d  = arburst_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awaddr_d   = awaddr_q;
    awlen_d    = awlen_q;
    awsize_d   = awsize_q;
    awburst_d  = awburst_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    wlast_d    = wlast_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bready_d   = bready_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (!busy_q && start) begin
      err_d     = 1'b0;
      mode_d    = (mode == 2'd3) ? 2'd0 : mode;
      rd_addr_d = src_addr;
      wr_addr_d = dst_addr;
      rd_rem_d  = num_beats;
      wr_rem_d  = num_beats;
      wr_idx_d  = '0;
      if (num_beats == 16'd0) begin
        done_d = 1'b1;
      end else begin
        busy_d     = 1'b1;
        wr_state_d = WR_AW;
        rd_state_d = (mode == 2'd2) ? RD_IDLE : RD_AR;
      end
    end

    // Read side: only one burst outstanding, so free space checked at AR cannot be stolen.
    case (rd_state_q)
      RD_AR: begin
        if (!arvalid_q) begin
          if (16'(free) >= rd_beats) begin
            arvalid_d = 1'b1;
            araddr_d  = rd_addr_q;
            arlen_d   = 4'(rd_beats - 16'd1);
            arsize_d  = 3'(SIZE);
            arburst_d = 2'b01;
          end
        end else if (arready) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          rd_state_d = RD_R;
          rd_addr_d  = rd_addr_q + (ADDR_WIDTH'(rd_beats) << SIZE);
          rd_rem_d   = rd_rem_q - rd_beats;
        end
      end
      RD_R: begin
        if (rvalid) begin
          push = 1'b1;
          if (rresp != 2'b00) err_d = 1'b1;
          if (rlast) begin
            rready_d   = 1'b0;
            rd_state_d = (rd_rem_q == 16'd0) ? RD_IDLE : RD_AR;
          end
        end
      end
      default: ;
    endcase

    // Write side: the whole burst is in the FIFO before AW, so wdata can be
    // preloaded from head and head+1 without ever waiting on the read side.
    case (wr_state_q)
      WR_AW: begin
        if (!awvalid_q) begin
          if (mode_q == 2'd2 || 16'(cnt_q) >= wr_beats) begin
            awvalid_d = 1'b1;
            awaddr_d  = wr_addr_q;
            awlen_d   = 4'(wr_beats - 16'd1);
            awsize_d  = 3'(SIZE);
            awburst_d = 2'b01;
          end
        end else if (awready) begin
          awvalid_d  = 1'b0;
          wr_state_d = WR_W;
          wr_burst_d = wr_beats;
          wr_beat_d  = '0;
          wr_addr_d  = wr_addr_q + (ADDR_WIDTH'(wr_beats) << SIZE);
          wr_rem_d   = wr_rem_q - wr_beats;
          wvalid_d   = 1'b1;
          wstrb_d    = '1;
          wlast_d    = (wr_beats == 16'd1);
          wdata_d    = xform(mode_q, fifo_mem_q[rd_ptr_q], wr_idx_q);
        end
      end
      WR_W: begin
        if (wready) begin
          pop      = (mode_q != 2'd2);
          wr_idx_d = wr_idx_q + 16'd1;
          if (wlast_q) begin
            wvalid_d   = 1'b0;
            wlast_d    = 1'b0;
            bready_d   = 1'b1;
            wr_state_d = WR_B;
          end else begin
            wr_beat_d = wr_beat_q + 16'd1;
            wlast_d   = (wr_beat_q + 16'd2 == wr_burst_q);
            wdata_d   = xform(mode_q, fifo_mem_q[rd_ptr_nxt], wr_idx_q + 16'd1);
          end
        end
      end
      WR_B: begin
        if (bvalid) begin
          bready_d = 1'b0;
          if (bresp != 2'b00) err_d = 1'b1;
          wr_state_d = (wr_rem_q == 16'd0) ? WR_FIN : WR_AW;
        end
      end
      WR_FIN: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        wr_state_d = WR_IDLE;
        rd_state_d = RD_IDLE;
      end
      default: ;
    endcase

    fifo_mem_d = fifo_mem_q;
    if (push) fifo_mem_d[wr_ptr_q] = rdata;
    wr_ptr_d = push ? wr_ptr_q + FA'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_nxt        : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (FA+1)'(1);
      2'b01:   cnt_d = cnt_q - (FA+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mode_q     <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      rd_rem_q   <= '0;
      wr_rem_q   <= '0;
      wr_burst_q <= '0;
      wr_beat_q  <= '0;
      wr_idx_q   <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arburst_q  <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      awsize_q   <= '0;
      awburst_q  <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bready_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mode_q     <= mode_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      rd_rem_q   <= rd_rem_d;
      wr_rem_q   <= wr_rem_d;
      wr_burst_q <= wr_burst_d;
      wr_beat_q  <= wr_beat_d;
      wr_idx_q   <= wr_idx_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arsize_q   <= arsize_d;
      arburst_q  <= arburst_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      awsize_q   <= awsize_d;
      awburst_q  <= awburst_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      wlast_q    <= wlast_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bready_q   <= bready_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage needs no reset; emptiness is defined by the pointers and count.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign arburst = arburst_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awaddr  = awaddr_q;
  assign awlen   = awlen_q;
  assign awsize  = awsize_q;
  assign awburst = awburst_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = wlast_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule
